dkongjr_wav_out: RTL and testbench
==================================

Name: dkongjr_wav_out

Overview:
- Downstream stage of the wave-sample address generator.
- Captures the 8-bit offset-binary byte returned by the sample ROM once per sample strobe, after a fixed ROM latency.
- Applies a 2-bit volume scale and produces an 8-bit offset-binary audio word for the sound mixer/DAC.
- When playback stops, ramps the output back to centre (0x80) so the mixer never sees a step (click).

Parameters:
- ROM_LAT, 2, clock cycles from I_SMP_STB to valid I_ROM_DB (range 1..8).
- FADE_STEP, 4, magnitude decrement per capture while fading (range 1..127).

Ports:
- I_CLK  input  1  system clock.
- I_RSTn  input  1  reset, asynchronous, active-low.
- I_ROM_DB  input  8  sample ROM data, offset-binary (0x80 = silence).
- I_SMP_STB  input  1  one-cycle pulse: ROM address has just advanced.
- I_ACTIVE  input  1  high while the upstream generator is playing a sample.
- I_VOL  input  2  volume select (3 = full, 0 = mute).
- O_WAV  output  8  audio word, offset-binary.
- O_VALID  output  1  one-cycle pulse: O_WAV was updated this cycle.
- O_BUSY  output  1  high when state is not IDLE.

Behaviour:
- Reset (async, immediate, including mid-play or mid-fade):
  - O_WAV = 0x80, O_VALID = 0, O_BUSY = 0.
  - State = IDLE, stored signed sample s = 0, strobe delay line cleared.
- Capture pulse cap:
  - cap = I_SMP_STB delayed ROM_LAT cycles through a shift register.
  - Overlapping strobes (spacing less than ROM_LAT) each produce their own cap.
  - Strobe in cycle n: I_ROM_DB, I_ACTIVE and I_VOL are sampled at the edge ending cycle n+ROM_LAT.
  - O_WAV and O_VALID=1 are visible in cycle n+ROM_LAT+1. Total latency is ROM_LAT+1 cycles.
- Conversion:
  - raw = signed 8-bit {~I_ROM_DB[7], I_ROM_DB[6:0]}.
  - Volume (arithmetic shifts): vol 3 -> raw; vol 2 -> raw - (raw>>>2); vol 1 -> raw>>>1; vol 0 -> 0.
  - O_WAV = s + 0x80, computed in 8 bits. No overflow is possible because |scaled| <= |raw|.
  - I_VOL is used only at cap edges.
- State machine (transitions only on cap edges; O_VALID pulses on every cap edge in all states):
  - IDLE:
    - cap with I_ACTIVE=1 -> PLAY; s = scaled raw.
    - Otherwise stay in IDLE with s = 0 (O_WAV = 0x80).
  - PLAY:
    - cap with I_ACTIVE=1 -> s = scaled raw; stay in PLAY.
    - cap with I_ACTIVE=0 -> FADE; s is held unchanged on this cap.
  - FADE:
    - cap with I_ACTIVE=1 -> PLAY immediately; s = scaled raw.
    - Otherwise step s toward zero: s>0 -> max(s-FADE_STEP, 0); s<0 -> min(s+FADE_STEP, 0).
    - If the resulting s == 0 -> IDLE.
    - FADE entered with s == 0 reaches IDLE on the next cap.
- Between cap edges O_WAV holds its value and O_VALID = 0.
- O_BUSY is a registered decode of state and changes on the same edge as the state.
- I_ACTIVE changes between caps have no effect until the next cap.
- With no strobes, the block holds its current state indefinitely. There is no timeout.

Test Plan:
- Reset then one strobe, ROM_LAT=2, I_ACTIVE=1, I_VOL=3, I_ROM_DB=0xC0 -> O_VALID pulses exactly 3 cycles after the strobe; O_WAV=0xC0; O_BUSY=1; state PLAY.
- Volume scaling, I_ROM_DB=0x00 (raw -128):
  - vol 2 -> O_WAV=0x20 (s=-96).
  - vol 1 -> O_WAV=0x40.
  - vol 0 -> O_WAV=0x80.
- Fade: play 0xC0 (s=+64), drop I_ACTIVE, FADE_STEP=4 -> next cap holds 0xC0, then 0xBC, 0xB8, ... 0x80. O_BUSY falls on the edge where s reaches 0, after 17 caps total.
- Negative fade from I_ROM_DB=0x7E (s=-2), FADE_STEP=4 -> clamps to 0x80 in one step; IDLE, no overshoot.
- Re-trigger during FADE: I_ACTIVE=1 at a cap with I_ROM_DB=0x10 -> immediate PLAY, O_WAV=0x10, no intermediate fade value.
- Async reset asserted mid-FADE and between clock edges -> O_WAV=0x80, O_BUSY=0, O_VALID=0 immediately. A strobe issued 1 cycle before reset produces no O_VALID after release.

Source files
------------

// File: rtl/dkongjr_wav_out.sv
// Wave-sample output stage: captures the sample ROM byte a fixed latency after
// each address strobe, applies a 2-bit volume scale and, when playback stops,
// ramps the output back to centre so the mixer never sees a step.
module dkongjr_wav_out #(
    parameter int unsigned ROM_LAT   = 2,
    parameter int unsigned FADE_STEP = 4
) (
    input  logic       I_CLK,
    input  logic       I_RSTn,
    input  logic [7:0] I_ROM_DB,
    input  logic       I_SMP_STB,
    input  logic       I_ACTIVE,
    input  logic [1:0] I_VOL,
    output logic [7:0] O_WAV,
    output logic       O_VALID,
    output logic       O_BUSY
);

    localparam logic signed [8:0] STEP9  = 9'(FADE_STEP);
    localparam logic        [7:0] CENTRE = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        FADE = 2'd2
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [ROM_LAT-1:0] stb_dly;
    logic               cap_c;
    logic signed [7:0]  s;
    logic signed [7:0]  nxt_s;
    logic signed [7:0]  raw_c;
    logic signed [7:0]  scaled_c;
    logic signed [7:0]  faded_c;
    logic signed [8:0]  s_ext_c;
    logic signed [8:0]  s_dn_c;
    logic signed [8:0]  s_up_c;

    assign cap_c = stb_dly[ROM_LAT-1];

    // Strobe delay line: one bit per outstanding ROM access, so overlapping strobes each capture.
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            stb_dly <= '0;
        end else begin
            stb_dly[0] <= I_SMP_STB;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                stb_dly[i] <= stb_dly[i-1];
            end
        end
    end

    // Offset-binary to signed, then volume scale by arithmetic shifts.
    always_comb begin
        raw_c    = {~I_ROM_DB[7], I_ROM_DB[6:0]};
        scaled_c = '0;
        case (I_VOL)
            2'd3:    scaled_c = raw_c;
            2'd2:    scaled_c = raw_c - (raw_c >>> 2);
            2'd1:    scaled_c = raw_c >>> 1;
            default: scaled_c = '0;
        endcase
    end

    // One fade step toward zero, clamped so the ramp never crosses centre.
    always_comb begin
        s_ext_c = 9'(s);
        s_dn_c  = s_ext_c - STEP9;
        s_up_c  = s_ext_c + STEP9;
        faded_c = s;
        if (s > 8'sd0) begin
            faded_c = (s_dn_c < 9'sd0) ? 8'sd0 : 8'(s_dn_c);
        end else if (s < 8'sd0) begin
            faded_c = (s_up_c > 9'sd0) ? 8'sd0 : 8'(s_up_c);
        end
    end

    // Next-state and next-sample decode; everything advances only on a capture.
    always_comb begin
        nxt_state = state;
        nxt_s     = s;
        if (cap_c) begin
            case (state)
                IDLE: begin
                    if (I_ACTIVE) begin
                        nxt_state = PLAY;
                        nxt_s     = scaled_c;
                    end else begin
                        nxt_s     = '0;
                    end
                end
                PLAY: begin
                    if (I_ACTIVE) begin
                        nxt_s     = scaled_c;
                    end else begin
                        nxt_state = FADE;
                    end
                end
                FADE: begin
                    if (I_ACTIVE) begin
                        nxt_state = PLAY;
                        nxt_s     = scaled_c;
                    end else begin
                        nxt_s     = faded_c;
                        if (faded_c == 8'sd0) begin
                            nxt_state = IDLE;
                        end
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_s     = '0;
                end
            endcase
        end
    end

    // State, sample and registered outputs.
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state   <= IDLE;
            s       <= '0;
            O_WAV   <= CENTRE;
            O_VALID <= 1'b0;
            O_BUSY  <= 1'b0;
        end else begin
            state   <= nxt_state;
            s       <= nxt_s;
            O_VALID <= cap_c;
            O_BUSY  <= (nxt_state != IDLE);
            if (cap_c) begin
                O_WAV <= 8'(nxt_s) + CENTRE;
            end
        end
    end

endmodule

// File: tb/tb_dkongjr_wav_out.sv
// Bench for dkongjr_wav_out: directed scenarios plus random stimulus, all
// checked cycle by cycle against a behavioural model of the output stage.
module tb_dkongjr_wav_out;

    localparam int unsigned ROM_LAT   = 2;
    localparam int unsigned FADE_STEP = 4;

    logic       I_CLK;
    logic       I_RSTn;
    logic [7:0] I_ROM_DB;
    logic       I_SMP_STB;
    logic       I_ACTIVE;
    logic [1:0] I_VOL;
    logic [7:0] O_WAV;
    logic       O_VALID;
    logic       O_BUSY;

    dkongjr_wav_out #(
        .ROM_LAT   (ROM_LAT),
        .FADE_STEP (FADE_STEP)
    ) dut (
        .I_CLK     (I_CLK),
        .I_RSTn    (I_RSTn),
        .I_ROM_DB  (I_ROM_DB),
        .I_SMP_STB (I_SMP_STB),
        .I_ACTIVE  (I_ACTIVE),
        .I_VOL     (I_VOL),
        .O_WAV     (O_WAV),
        .O_VALID   (O_VALID),
        .O_BUSY    (O_BUSY)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: playing/fading flag, signed sample value, and the cycle numbers at which captures fall due.
    int m_s      = 0;
    bit m_play   = 0;
    bit m_fade   = 0;
    bit m_valid  = 0;
    int cyc      = 0;
    int due_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int floor_div(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int scale(input int db, input int vol);
        int raw;
        raw = db - 128;
        case (vol)
            3:       return raw;
            2:       return raw - floor_div(raw, 4);
            1:       return floor_div(raw, 2);
            default: return 0;
        endcase
    endfunction

    // Apply one cycle of inputs, advance the model, clock, then compare all outputs.
    task automatic step(input bit stb, input bit act, input int vol, input int db);
        bit cap;
        int sc;
        I_SMP_STB = stb;
        I_ACTIVE  = act;
        I_VOL     = 2'(vol);
        I_ROM_DB  = 8'(db);
        cap = (due_q.size() > 0 && due_q[0] == cyc);
        if (cap) void'(due_q.pop_front());
        if (stb) due_q.push_back(cyc + int'(ROM_LAT));
        m_valid = cap;
        if (cap) begin
            sc = scale(db, vol);
            if (act) begin
                m_play = 1; m_fade = 0; m_s = sc;
            end else if (m_fade) begin
                if (m_s > 0) m_s = (m_s - int'(FADE_STEP) < 0) ? 0 : m_s - int'(FADE_STEP);
                else if (m_s < 0) m_s = (m_s + int'(FADE_STEP) > 0) ? 0 : m_s + int'(FADE_STEP);
                if (m_s == 0) m_fade = 0;
            end else if (m_play) begin
                m_play = 0; m_fade = 1;
            end else begin
                m_s = 0;
            end
        end
        @(posedge I_CLK);
        cyc++;
        #1;
        check("valid", int'(O_VALID), int'(m_valid));
        check("wav",   int'(O_WAV),   m_s + 128);
        check("busy",  int'(O_BUSY),  int'(m_play || m_fade));
    endtask

    // One strobe, inputs held until its capture edge has passed.
    task automatic play(input bit act, input int vol, input int db);
        step(1'b1, act, vol, db);
        repeat (ROM_LAT) step(1'b0, act, vol, db);
    endtask

    // Assert reset between edges, check outputs react at once, release on the next falling edge.
    task automatic async_reset();
        #2;
        I_RSTn = 1'b0;
        #1;
        check("rst_wav",   int'(O_WAV),   'h80);
        check("rst_valid", int'(O_VALID), 0);
        check("rst_busy",  int'(O_BUSY),  0);
        due_q.delete();
        m_s = 0; m_play = 0; m_fade = 0; m_valid = 0;
        @(negedge I_CLK);
        I_RSTn = 1'b1;
    endtask

    initial begin
        bit act;
        I_RSTn = 1'b0; I_SMP_STB = 1'b0; I_ACTIVE = 1'b0; I_VOL = 2'd3; I_ROM_DB = 8'h80;
        repeat (3) @(posedge I_CLK);
        #1;
        check("reset_wav",   int'(O_WAV),   'h80);
        check("reset_valid", int'(O_VALID), 0);
        check("reset_busy",  int'(O_BUSY),  0);
        @(negedge I_CLK);
        I_RSTn = 1'b1;

        // First capture latency and value.
        step(1'b1, 1'b1, 3, 'hC0);
        check("lat_early0", int'(O_VALID), 0);
        step(1'b0, 1'b1, 3, 'hC0);
        check("lat_early1", int'(O_VALID), 0);
        step(1'b0, 1'b1, 3, 'hC0);
        check("lat_valid", int'(O_VALID), 1);
        check("lat_wav",   int'(O_WAV),   'hC0);
        check("lat_busy",  int'(O_BUSY),  1);
        step(1'b0, 1'b1, 3, 'hC0);
        check("lat_pulse", int'(O_VALID), 0);

        // Volume scaling of the most negative sample.
        play(1'b1, 2, 'h00); check("vol2", int'(O_WAV), 'h20);
        play(1'b1, 1, 'h00); check("vol1", int'(O_WAV), 'h40);
        play(1'b1, 0, 'h00); check("vol0", int'(O_WAV), 'h80);

        // Positive fade: hold, then 16 steps of 4 down to centre.
        play(1'b1, 3, 'hC0);
        for (int k = 0; k < 17; k++) begin
            play(1'b0, 3, 'hC0);
            check("fade_wav",  int'(O_WAV),  (k == 0) ? 'hC0 : 'hC0 - 4 * k);
            check("fade_busy", int'(O_BUSY), (k < 16) ? 1 : 0);
        end

        // Negative fade clamps without overshoot.
        play(1'b1, 3, 'h7E); check("neg_wav0", int'(O_WAV), 'h7E);
        play(1'b0, 3, 'h7E); check("neg_hold", int'(O_WAV), 'h7E);
        play(1'b0, 3, 'h7E); check("neg_wav1", int'(O_WAV), 'h80);
        check("neg_busy", int'(O_BUSY), 0);

        // Re-trigger during fade goes straight to the new sample.
        play(1'b1, 3, 'hC0);
        play(1'b0, 3, 'hC0);
        play(1'b0, 3, 'hC0); check("retrig_fade", int'(O_WAV), 'hBC);
        play(1'b1, 3, 'h10); check("retrig_wav",  int'(O_WAV), 'h10);
        check("retrig_busy", int'(O_BUSY), 1);

        // Async reset mid-fade with a strobe in flight.
        play(1'b1, 3, 'hC0);
        play(1'b0, 3, 'hC0);
        play(1'b0, 3, 'hC0);
        step(1'b1, 1'b1, 3, 'hF0);
        async_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 3, 'hF0);
            check("post_rst_valid", int'(O_VALID), 0);
        end

        // Random traffic, including overlapping strobes and occasional resets.
        act = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(15) == 0) act = ~act;
            if ($urandom_range(999) == 0) async_reset();
            step(($urandom_range(2) == 0), act, int'($urandom_range(3)), int'($urandom_range(255)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
